// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator display path.
// Imported by the BCD converter and the digit scanner.
package calc_disp_pkg;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;
    localparam int         MAX_DISPLAY = 9999;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_e;

    typedef logic [3:0]  bcd_t;
    typedef bcd_t [3:0]  disp_t;

endpackage

// File: rtl/digit_scanner.sv
// Free-running multiplexer that walks the display register one digit
// at a time, holding each position for SCAN_DIV clocks.
module digit_scanner
    import calc_disp_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DIGITS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  disp_t             disp_i,
    output bcd_t              digit_o,
    output logic [DIGITS-1:0] sel_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    bcd_t              digit_q, digit_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic              wrap;

    // digit tracks the display every cycle so a commit shows up one
    // clock later without touching the scan position.
    always_comb begin
        wrap    = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        idx_d   = wrap ? idx_q + 1'b1 : idx_q;
        digit_d = disp_i[idx_d];
        sel_d   = DIGITS'(1) << idx_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            digit_q <= BLANK_DIGIT;
            sel_q   <= DIGITS'(1);
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            sel_q   <= sel_d;
        end
    end

    assign digit_o = digit_q;
    assign sel_o   = sel_q;

endmodule

// File: rtl/bcd_scan_driver.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding a
// blanked display register that a free-running scanner multiplexes.
module bcd_scan_driver
    import calc_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int VAL_W    = 14,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [VAL_W-1:0]  value,
    input  logic              load,
    output logic              busy,
    output logic              overflow,
    output logic [3:0]        digit,
    output logic [DIGITS-1:0] digit_sel
);

    localparam int CW = $clog2(VAL_W);

    state_e           state_q, state_d;
    logic [VAL_W-1:0] bin_q, bin_d;
    disp_t            bcd_q, bcd_d;
    logic [CW-1:0]    bcnt_q, bcnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    disp_t            disp_q, disp_d;
    logic             ovf_q, ovf_d;
    disp_t            adj;
    disp_t            blanked;
    logic             seen;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i] >= 4'd5) adj[i] = bcd_q[i] + 4'd3;
        end
    end

    // Zeros above the leading nonzero digit blank; digit 0 always shows.
    always_comb begin
        blanked = bcd_q;
        seen    = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            if (bcd_q[i] != 4'd0) seen = 1'b1;
            if (!seen) blanked[i] = BLANK_DIGIT;
        end
        if (ovf_pend_q) blanked = {4{BLANK_DIGIT}};
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bcnt_d     = bcnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d      = value;
                    bcd_d      = '0;
                    bcnt_d     = CW'(VAL_W - 1);
                    ovf_pend_d = (value > VAL_W'(MAX_DISPLAY));
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                bcnt_d         = bcnt_q - 1'b1;
                if (bcnt_q == '0) state_d = COMMIT;
            end
            COMMIT: begin
                disp_d  = blanked;
                ovf_d   = ovf_pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            bcnt_q     <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= {4{BLANK_DIGIT}};
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bcnt_q     <= bcnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign overflow = ovf_q;

    digit_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DIGITS   (DIGITS)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .disp_i  (disp_q),
        .digit_o (digit),
        .sel_o   (digit_sel)
    );

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver with a 4-cycle scan period.
module tb_bcd_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic        overflow;
    logic [3:0]  digit;
    logic [3:0]  digit_sel;

    int total = 0;
    int bad   = 0;

    bcd_scan_driver #(
        .DIGITS   (4),
        .VAL_W    (14),
        .SCAN_DIV (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .load      (load),
        .busy      (busy),
        .overflow  (overflow),
        .digit     (digit),
        .digit_sel (digit_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_load(input logic [13:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Counts negedges with busy high, starting just after the load edge.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Samples a full scan and assembles {pos3,pos2,pos1,pos0}.
    task automatic capture(output logic [15:0] d);
        d = 16'hxxxx;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            case (digit_sel)
                4'b0001: d[3:0]   = digit;
                4'b0010: d[7:4]   = digit;
                4'b0100: d[11:8]  = digit;
                4'b1000: d[15:12] = digit;
                default: ;
            endcase
            @(negedge clk);
        end
    endtask

    task automatic convert_check(input string nm, input logic [13:0] v,
                                 input logic [15:0] exp_d, input logic exp_o);
        int          n;
        logic [15:0] d;
        start_load(v);
        wait_idle(n);
        total++;
        if (n !== 15) begin
            bad++;
            $display("FAIL %s busy_len got=%0d want=15", nm, n);
        end
        capture(d);
        total++;
        if (d !== exp_d) begin
            bad++;
            $display("FAIL %s display got=%h want=%h", nm, d, exp_d);
        end
        total++;
        if (overflow !== exp_o) begin
            bad++;
            $display("FAIL %s overflow got=%b want=%b", nm, overflow, exp_o);
        end
    endtask

    task automatic test_reset();
        logic [3:0] es;
        rst_n = 1'b0;
        value = '0;
        load  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            es = 4'b0001 << ((k / 4) % 4);
            total++;
            if (digit_sel !== es || digit !== 4'hF || busy !== 1'b0
                || overflow !== 1'b0) begin
                bad++;
                $display("FAIL reset_scan k=%0d sel=%b dig=%h busy=%b ovf=%b want sel=%b dig=f 0 0",
                         k, digit_sel, digit, busy, overflow, es);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_convert();
        convert_check("v1234", 14'd1234, 16'h1234, 1'b0);
    endtask

    task automatic test_blanking();
        convert_check("v7", 14'd7, 16'hFFF7, 1'b0);
        convert_check("v0", 14'd0, 16'hFFF0, 1'b0);
        convert_check("v305", 14'd305, 16'hF305, 1'b0);
    endtask

    task automatic test_overflow();
        convert_check("v12000", 14'd12000, 16'hFFFF, 1'b1);
        convert_check("v9999", 14'd9999, 16'h9999, 1'b0);
        convert_check("v10000", 14'd10000, 16'hFFFF, 1'b1);
        convert_check("v1000", 14'd1000, 16'h1000, 1'b0);
    endtask

    task automatic test_back_to_back();
        int          n;
        logic [15:0] d;
        start_load(14'd1234);
        repeat (3) @(negedge clk);
        value = 14'd5678;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_idle(n);
        total++;
        if (n !== 15 - 4) begin
            bad++;
            $display("FAIL ignore_busy_len got=%0d want=11", n);
        end
        capture(d);
        total++;
        if (d !== 16'h1234) begin
            bad++;
            $display("FAIL ignore_display got=%h want=1234", d);
        end
        convert_check("v5678", 14'd5678, 16'h5678, 1'b0);
    endtask

    task automatic test_mid_reset();
        logic [15:0] d;
        start_load(14'd4321);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || digit_sel !== 4'b0001 || digit !== 4'hF
            || overflow !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async busy=%b sel=%b dig=%h ovf=%b want 0 0001 f 0",
                     busy, digit_sel, digit, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) break;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_busy got=%b want=0", busy);
        end
        capture(d);
        total++;
        if (d !== 16'hFFFF) begin
            bad++;
            $display("FAIL midrst_display got=%h want=ffff", d);
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_blanking();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
